// File: rtl/exu_mdu_pkg.sv
// rtl/exu_mdu_pkg.sv - shared constants and types for the RV32M multiply/divide unit
//
// Contents:
//   F3_MUL..F3_REMU  funct3 codes of the M extension
//   FUNCT7_M         funct7 value selecting the M extension in OP instructions
//   mdu_state_e      FSM states MDU_IDLE / MDU_CALC / MDU_DONE
package exu_mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_M  = 7'b000_0001;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - restoring divider datapath, one quotient bit per step
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          load dividend/divisor magnitudes, clear partial remainder
//   step_i          perform one restoring-subtract step
//   dividend_i      unsigned dividend (magnitude)
//   divisor_i       unsigned divisor (magnitude, non-zero when stepping)
//   quotient_o      quotient register (final after XLEN steps)
//   remainder_o     partial remainder register (final after XLEN steps)
module mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] diff;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the remainder while quotient bits enter at the LSB.
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[XLEN-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        // When fits is set the true difference is below the divisor, so the
        // low XLEN bits of the truncated subtraction are exact.
        diff    = shifted[XLEN-1:0] - dvs_q;
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d = fits ? diff : shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], fits};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/exu_mdu.sv
// rtl/exu_mdu.sv - iterative RV32M multiply/divide unit beside the execute stage
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      op request, taken only while busy_o is low
//   kill_i       abort the op in flight (pipeline flush); wins over start_i
//   funct3_i     M-extension operation code
//   op1_i/op2_i  rs1/rs2 values
//   rd_i         destination register carried with the op
//   busy_o       op in progress (CALC or DONE)
//   valid_o      one-cycle result strobe for the regfile write
//   result_o     result; holds the previous result outside valid_o
//   rd_o         destination register of result_o
//
// Build option: define MDU_FAST_MUL_EN to compute all multiplies with a
// single-cycle array multiplier (IDLE -> DONE); division stays iterative.
module exu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    import exu_mdu_pkg::*;

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic              eo_q, eo_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              op1_signed, op2_signed, s1, s2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf, early;
    logic [XLEN-1:0]   eo_val;
    logic              neg_in;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quotient, remainder;
    logic [XLEN-1:0]   res_final;
    logic              div_load, div_step;

    // Operand decode: signed operands are converted to magnitudes; the sign
    // of the final result is remembered in neg_q and applied in DONE.
    always_comb begin
        op1_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                     (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        op2_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) ||
                     (funct3_i == F3_REM);
        s1       = op1_signed & op1_i[XLEN-1];
        s2       = op2_signed & op2_i[XLEN-1];
        mag1     = s1 ? -op1_i : op1_i;
        mag2     = s2 ? -op2_i : op2_i;
        div_zero = funct3_i[2] && (op2_i == '0);
        div_ovf  = funct3_i[2] && !funct3_i[0] && (op1_i == MIN_INT) && (op2_i == '1);
        early    = div_zero || div_ovf;
        // funct3[1] separates REM/REMU from DIV/DIVU
        if (div_zero) begin
            eo_val = funct3_i[1] ? op1_i : '1;
        end else begin
            eo_val = funct3_i[1] ? '0 : MIN_INT;
        end
        // remainder follows the dividend, everything else the operand xor
        neg_in = (funct3_i[2] && funct3_i[1]) ? s1 : (s1 ^ s2);
    end

    // Shift-add multiplier: p_q starts as {0, multiplier}; each step adds
    // the multiplicand to the upper half when the LSB is set, then shifts.
    assign mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});

    always_comb begin
        prod_fix = neg_q ? -p_q : p_q;
        if (eo_q) begin
            res_final = p_q[XLEN-1:0];
        end else if (!f3_q[2]) begin
            res_final = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (f3_q[1]) begin
            res_final = neg_q ? -remainder : remainder;
        end else begin
            res_final = neg_q ? -quotient : quotient;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        eo_d     = eo_q;
        a_d      = a_q;
        p_d      = p_q;
        div_load = 1'b0;
        div_step = 1'b0;
        busy_o   = (state_q != MDU_IDLE);
        // a kill arriving during DONE still suppresses the write-back
        valid_o  = (state_q == MDU_DONE) && !kill_i;
        unique case (state_q)
            MDU_IDLE: begin
                if (start_i && !kill_i) begin
                    f3_d  = funct3_i;
                    rd_d  = rd_i;
                    neg_d = neg_in;
                    a_d   = mag1;
                    cnt_d = '0;
                    if (early) begin
                        eo_d    = 1'b1;
                        p_d     = {{XLEN{1'b0}}, eo_val};
                        state_d = MDU_DONE;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (!funct3_i[2]) begin
                        eo_d    = 1'b0;
                        p_d     = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
                        state_d = MDU_DONE;
                    end
`endif
                    else begin
                        eo_d     = 1'b0;
                        p_d      = {{XLEN{1'b0}}, mag2};
                        div_load = funct3_i[2];
                        state_d  = MDU_CALC;
                    end
                end
            end
            MDU_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (f3_q[2]) begin
                    div_step = 1'b1;
                end else begin
                    p_d = {mul_sum, p_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
        if (kill_i) begin
            state_d  = MDU_IDLE;
            div_load = 1'b0;
            div_step = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            eo_q     <= 1'b0;
            a_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            f3_q  <= f3_d;
            rd_q  <= rd_d;
            neg_q <= neg_d;
            eo_q  <= eo_d;
            a_q   <= a_d;
            p_q   <= p_d;
            if (valid_o) begin
                result_q <= res_final;
                rd_out_q <= rd_q;
            end
        end
    end

    // The result is visible during the DONE cycle and then held in result_q.
    assign result_o = valid_o ? res_final : result_q;
    assign rd_o     = valid_o ? rd_q : rd_out_q;

    mdu_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (mag1),
        .divisor_i   (mag2),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

endmodule
